// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multicycle RV32I sequencer over one shared memory port.
// Steps FETCH/DECODE/EXEC/MEM/WB and drives datapath selects and enables.
module riscv_mc_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int INSTRET_W   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [6:0]           i_mc_opcode,
  input  logic [2:0]           i_mc_funct3,
  input  logic                 i_mc_funct7_5b,
  input  logic                 i_mc_alu_zero,
  input  logic                 i_mc_mem_ready,
  output logic                 o_mc_mem_req,
  output logic                 o_mc_mem_wr_en,
  output logic                 o_mc_mem_addr_src,
  output logic [3:0]           o_mc_mem_byte_sel,
  output logic                 o_mc_ir_wr_en,
  output logic                 o_mc_pc_wr_en,
  output logic [1:0]           o_mc_src_pc,
  output logic [2:0]           o_mc_src_imm,
  output logic [1:0]           o_mc_src_rd,
  output logic                 o_mc_src_alu_a,
  output logic                 o_mc_src_alu_b,
  output logic [3:0]           o_mc_alu_ctrl,
  output logic                 o_mc_reg_wr_en,
  output logic [2:0]           o_mc_state,
  output logic                 o_mc_fault,
  output logic [INSTRET_W-1:0] o_mc_instret
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] PC_4      = 2'd0;
  localparam logic [1:0] PC_IMM    = 2'd1;
  localparam logic [1:0] PC_RS_IMM = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] RD_ALU = 2'd0;
  localparam logic [1:0] RD_DME = 2'd1;
  localparam logic [1:0] RD_PC4 = 2'd2;
  localparam logic [1:0] RD_IMM = 2'd3;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit TMO_EN = (MEM_TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [INSTRET_W-1:0]   instret_q;
  logic                   retire;
  logic                   is_load, is_store, is_branch, opc_valid;
  logic                   br_take, tmo_hit;
  logic [3:0]             arith_op;

  assign is_load   = (i_mc_opcode == OPC_LOAD);
  assign is_store  = (i_mc_opcode == OPC_STORE);
  assign is_branch = (i_mc_opcode == OPC_BRANCH);
  assign opc_valid = (i_mc_opcode == OPC_LUI)   || (i_mc_opcode == OPC_AUIPC)
                  || (i_mc_opcode == OPC_JAL)   || (i_mc_opcode == OPC_JALR)
                  || is_branch || is_load || is_store
                  || (i_mc_opcode == OPC_OPIMM) || (i_mc_opcode == OPC_OP);
  assign tmo_hit   = TMO_EN && (tmo_q == TMO_LAST);

  // Branch outcome from the compare result; undefined funct3 never takes
  always_comb begin
    br_take = 1'b0;
    case (i_mc_funct3)
      3'b000:  br_take =  i_mc_alu_zero;
      3'b001:  br_take = !i_mc_alu_zero;
      3'b100:  br_take = !i_mc_alu_zero;
      3'b101:  br_take =  i_mc_alu_zero;
      3'b110:  br_take = !i_mc_alu_zero;
      3'b111:  br_take =  i_mc_alu_zero;
      default: br_take = 1'b0;
    endcase
  end

  // Register/immediate arithmetic op; SUB only exists in the reg-reg form
  always_comb begin
    arith_op = ALU_ADD;
    case (i_mc_funct3)
      3'b000: arith_op = (i_mc_funct7_5b && i_mc_opcode == OPC_OP)
                         ? ALU_SUB : ALU_ADD;
      3'b001: arith_op = ALU_SLL;
      3'b010: arith_op = ALU_SLT;
      3'b011: arith_op = ALU_SLTU;
      3'b100: arith_op = ALU_XOR;
      3'b101: arith_op = i_mc_funct7_5b ? ALU_SRA : ALU_SRL;
      3'b110: arith_op = ALU_OR;
      3'b111: arith_op = ALU_AND;
      default: arith_op = ALU_ADD;
    endcase
  end

  // Datapath selects decoded straight from the IR fields
  always_comb begin
    o_mc_src_imm   = IMM_I;
    o_mc_src_alu_a = 1'b0;
    o_mc_src_alu_b = 1'b1;
    o_mc_alu_ctrl  = ALU_ADD;
    o_mc_src_rd    = RD_ALU;
    o_mc_src_pc    = PC_4;
    unique case (i_mc_opcode)
      OPC_OP: begin
        o_mc_src_alu_b = 1'b0;
        o_mc_alu_ctrl  = arith_op;
      end
      OPC_OPIMM: o_mc_alu_ctrl = arith_op;
      OPC_LUI: begin
        o_mc_src_imm = IMM_U;
        o_mc_src_rd  = RD_IMM;
      end
      OPC_AUIPC: begin
        o_mc_src_imm   = IMM_U;
        o_mc_src_alu_a = 1'b1;
      end
      OPC_JAL: begin
        o_mc_src_imm = IMM_J;
        o_mc_src_rd  = RD_PC4;
        o_mc_src_pc  = PC_IMM;
      end
      OPC_JALR: begin
        o_mc_src_rd = RD_PC4;
        o_mc_src_pc = PC_RS_IMM;
      end
      OPC_BRANCH: begin
        o_mc_src_imm   = IMM_B;
        o_mc_src_alu_b = 1'b0;
        o_mc_src_pc    = br_take ? PC_IMM : PC_4;
        unique case (i_mc_funct3[2:1])
          2'b10:   o_mc_alu_ctrl = ALU_SLT;
          2'b11:   o_mc_alu_ctrl = ALU_SLTU;
          default: o_mc_alu_ctrl = ALU_SUB;
        endcase
      end
      OPC_LOAD:  o_mc_src_rd  = RD_DME;
      OPC_STORE: o_mc_src_imm = IMM_S;
      default: ;
    endcase
  end

  // Next state and state-gated enables; reset kills every enable at once
  always_comb begin
    state_d        = state_q;
    o_mc_mem_req   = 1'b0;
    o_mc_mem_wr_en = 1'b0;
    o_mc_ir_wr_en  = 1'b0;
    o_mc_pc_wr_en  = 1'b0;
    o_mc_reg_wr_en = 1'b0;
    retire         = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        o_mc_mem_req = 1'b1;
        if (i_mc_mem_ready) begin
          o_mc_ir_wr_en = 1'b1;
          state_d       = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = opc_valid ? S_EXEC : S_FAULT;
      S_EXEC: begin
        if (is_branch) begin
          o_mc_pc_wr_en = 1'b1;
          retire        = 1'b1;
          state_d       = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        o_mc_mem_req   = 1'b1;
        o_mc_mem_wr_en = is_store;
        if (i_mc_mem_ready) begin
          if (is_store) begin
            o_mc_pc_wr_en = 1'b1;
            retire        = 1'b1;
            state_d       = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        o_mc_reg_wr_en = 1'b1;
        o_mc_pc_wr_en  = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      default: state_d = S_FAULT;
    endcase
    if (i_rst) begin
      o_mc_mem_req   = 1'b0;
      o_mc_mem_wr_en = 1'b0;
      o_mc_ir_wr_en  = 1'b0;
      o_mc_pc_wr_en  = 1'b0;
      o_mc_reg_wr_en = 1'b0;
    end
  end

  // Stall counter restarts on every state change
  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q)
      tmo_d = '0;
    else if (o_mc_mem_req && !i_mc_mem_ready)
      tmo_d = tmo_q + 1'b1;
  end

  // State, stall counter and retired count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_FETCH;
      tmo_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (retire)
        instret_q <= instret_q + 1'b1;
    end
  end

  // Byte lanes: fetch is always a word, data access follows funct3
  always_comb begin
    o_mc_mem_byte_sel = 4'b1111;
    if (state_q == S_MEM) begin
      case (i_mc_funct3[1:0])
        2'b00:   o_mc_mem_byte_sel = 4'b0001;
        2'b01:   o_mc_mem_byte_sel = 4'b0011;
        default: o_mc_mem_byte_sel = 4'b1111;
      endcase
    end
  end

  assign o_mc_mem_addr_src = (state_q == S_MEM);
  assign o_mc_state        = state_q;
  assign o_mc_fault        = (state_q == S_FAULT);
  assign o_mc_instret      = instret_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: decode vector table, directed multicycle sequences
// and randomized instruction streams against a per-instruction model.
module tb_riscv_mc_ctrl;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLT = 3, ALU_SLTU = 4;
  localparam int ALU_SRL = 6, ALU_SRA = 7, ALU_AND = 9;
  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_EXEC = 2;
  localparam int ST_MEM = 3, ST_WB = 4, ST_FAULT = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] f3 = '0;
  logic       f7 = 1'b0;
  logic       zero = 1'b0;
  logic       rdy = 1'b0;

  logic       o_req, o_wr, o_asrc, o_ir, o_pcw, o_alu_a, o_alu_b;
  logic       o_regw, o_fault;
  logic [3:0] o_bsel, o_alu;
  logic [1:0] o_spc, o_srd;
  logic [2:0] o_simm, o_state;
  logic [3:0] o_instret;

  int nchk = 0;
  int nerr = 0;
  int retired = 0;

  riscv_mc_ctrl #(.MEM_TIMEOUT(4), .INSTRET_W(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_mc_opcode(op), .i_mc_funct3(f3), .i_mc_funct7_5b(f7),
    .i_mc_alu_zero(zero), .i_mc_mem_ready(rdy),
    .o_mc_mem_req(o_req), .o_mc_mem_wr_en(o_wr),
    .o_mc_mem_addr_src(o_asrc), .o_mc_mem_byte_sel(o_bsel),
    .o_mc_ir_wr_en(o_ir), .o_mc_pc_wr_en(o_pcw),
    .o_mc_src_pc(o_spc), .o_mc_src_imm(o_simm), .o_mc_src_rd(o_srd),
    .o_mc_src_alu_a(o_alu_a), .o_mc_src_alu_b(o_alu_b),
    .o_mc_alu_ctrl(o_alu), .o_mc_reg_wr_en(o_regw),
    .o_mc_state(o_state), .o_mc_fault(o_fault), .o_mc_instret(o_instret)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int alu; int spc; int srd; int imm; int a; int b;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_taken(input logic [2:0] f, input logic z);
    case (f)
      3'b000: return int'(z);
      3'b001: return int'(!z);
      3'b100: return int'(!z);
      3'b101: return int'(z);
      3'b110: return int'(!z);
      3'b111: return int'(z);
      default: return 0;
    endcase
  endfunction

  function automatic int exp_pc(input logic [6:0] o, input logic [2:0] f,
                                input logic z);
    if (o == OPC_JAL) return 1;
    if (o == OPC_JALR) return 2;
    if (o == OPC_BRANCH) return exp_taken(f, z);
    return 0;
  endfunction

  function automatic int exp_rd(input logic [6:0] o);
    if (o == OPC_LOAD) return 1;
    if (o == OPC_JAL || o == OPC_JALR) return 2;
    if (o == OPC_LUI) return 3;
    return 0;
  endfunction

  function automatic int exp_bs(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 3;
    return 15;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", int'(o_state), ST_FETCH);
    chk("rst.req", int'(o_req), 0);
    chk("rst.fault", int'(o_fault), 0);
    chk("rst.instret", int'(o_instret), 0);
    rst = 1'b0;
    retired = 0;
  endtask

  // One instruction: expected state trace built from the stage rules,
  // ready driven dF/dM cycles late in FETCH/MEM, random elsewhere.
  task automatic run_instr(input string nm, input logic [6:0] o,
                           input logic [2:0] f, input logic s7,
                           input logic z, input int dF, input int dM);
    int  trace[$];
    int  fi = 0;
    int  mi = 0;
    bit  ld = (o == OPC_LOAD);
    bit  st = (o == OPC_STORE);
    bit  br = (o == OPC_BRANCH);
    repeat (dF + 1) trace.push_back(ST_FETCH);
    trace.push_back(ST_DECODE);
    trace.push_back(ST_EXEC);
    if (ld || st) repeat (dM + 1) trace.push_back(ST_MEM);
    if (!(br || st)) trace.push_back(ST_WB);
    op = o; f3 = f; f7 = s7; zero = z;
    for (int k = 0; k < trace.size(); k++) begin
      int es = trace[k];
      bit last = (k == trace.size() - 1);
      if (es == ST_FETCH) rdy = (fi == dF);
      else if (es == ST_MEM) rdy = (mi == dM);
      else rdy = 1'($urandom_range(0, 1));
      #1;
      chk({nm, ".state"}, int'(o_state), es);
      chk({nm, ".req"}, int'(o_req), int'(es == ST_FETCH || es == ST_MEM));
      chk({nm, ".wr_en"}, int'(o_wr), int'(es == ST_MEM && st));
      chk({nm, ".pc_wr"}, int'(o_pcw), int'(last));
      chk({nm, ".reg_wr"}, int'(o_regw), int'(es == ST_WB));
      chk({nm, ".ir_wr"}, int'(o_ir), int'(es == ST_FETCH && rdy));
      if (es == ST_FETCH) begin
        chk({nm, ".f_bsel"}, int'(o_bsel), 15);
        chk({nm, ".f_asrc"}, int'(o_asrc), 0);
      end
      if (es == ST_MEM) begin
        chk({nm, ".m_bsel"}, int'(o_bsel), exp_bs(f));
        chk({nm, ".m_asrc"}, int'(o_asrc), 1);
      end
      if (es == ST_WB) chk({nm, ".src_rd"}, int'(o_srd), exp_rd(o));
      if (last) chk({nm, ".src_pc"}, int'(o_spc), exp_pc(o, f, z));
      if (es == ST_EXEC && br && f[2:1] != 2'b01)
        chk({nm, ".br_alu"}, int'(o_alu),
            f[2] ? (f[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB);
      if (es == ST_FETCH) fi++;
      if (es == ST_MEM) mi++;
      @(posedge clk);
      #1;
    end
    retired++;
    chk({nm, ".instret"}, int'(o_instret), retired % 16);
  endtask

  logic [6:0] opcs [9];
  vec_t       tbl [16];

  initial begin
    opcs[0] = OPC_LUI;    opcs[1] = OPC_AUIPC; opcs[2] = OPC_JAL;
    opcs[3] = OPC_JALR;   opcs[4] = OPC_BRANCH; opcs[5] = OPC_LOAD;
    opcs[6] = OPC_STORE;  opcs[7] = OPC_OPIMM; opcs[8] = OPC_OP;

    tbl[0]  = '{OPC_OPIMM,  3'b000, 1'b1, 1'b0, ALU_ADD,  0, 0, 0, 0, 1};
    tbl[1]  = '{OPC_OP,     3'b000, 1'b0, 1'b0, ALU_ADD,  0, 0, 0, 0, 0};
    tbl[2]  = '{OPC_OP,     3'b000, 1'b1, 1'b0, ALU_SUB,  0, 0, 0, 0, 0};
    tbl[3]  = '{OPC_OP,     3'b101, 1'b1, 1'b0, ALU_SRA,  0, 0, 0, 0, 0};
    tbl[4]  = '{OPC_OPIMM,  3'b101, 1'b0, 1'b0, ALU_SRL,  0, 0, 0, 0, 1};
    tbl[5]  = '{OPC_OPIMM,  3'b101, 1'b1, 1'b0, ALU_SRA,  0, 0, 0, 0, 1};
    tbl[6]  = '{OPC_OP,     3'b011, 1'b0, 1'b0, ALU_SLTU, 0, 0, 0, 0, 0};
    tbl[7]  = '{OPC_OP,     3'b111, 1'b0, 1'b0, ALU_AND,  0, 0, 0, 0, 0};
    tbl[8]  = '{OPC_LUI,    3'b000, 1'b0, 1'b0, ALU_ADD,  0, 3, 3, 0, 1};
    tbl[9]  = '{OPC_AUIPC,  3'b000, 1'b0, 1'b0, ALU_ADD,  0, 0, 3, 1, 1};
    tbl[10] = '{OPC_JAL,    3'b000, 1'b0, 1'b0, ALU_ADD,  1, 2, 4, 0, 1};
    tbl[11] = '{OPC_JALR,   3'b000, 1'b0, 1'b0, ALU_ADD,  2, 2, 0, 0, 1};
    tbl[12] = '{OPC_BRANCH, 3'b100, 1'b0, 1'b0, ALU_SLT,  1, 0, 2, 0, 0};
    tbl[13] = '{OPC_BRANCH, 3'b111, 1'b0, 1'b0, ALU_SLTU, 0, 0, 2, 0, 0};
    tbl[14] = '{OPC_BRANCH, 3'b010, 1'b0, 1'b1, ALU_SUB,  0, 0, 2, 0, 0};
    tbl[15] = '{OPC_LOAD,   3'b010, 1'b0, 1'b0, ALU_ADD,  0, 1, 0, 0, 1};

    // Combinational decode table, applied while held in reset
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      op = tbl[i].op; f3 = tbl[i].f3; f7 = tbl[i].f7; zero = tbl[i].z;
      #2;
      chk($sformatf("tbl%0d.alu", i), int'(o_alu), tbl[i].alu);
      chk($sformatf("tbl%0d.src_pc", i), int'(o_spc), tbl[i].spc);
      chk($sformatf("tbl%0d.src_rd", i), int'(o_srd), tbl[i].srd);
      chk($sformatf("tbl%0d.src_imm", i), int'(o_simm), tbl[i].imm);
      chk($sformatf("tbl%0d.alu_a", i), int'(o_alu_a), tbl[i].a);
      chk($sformatf("tbl%0d.alu_b", i), int'(o_alu_b), tbl[i].b);
    end

    do_reset();
    run_instr("addi", OPC_OPIMM, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr("lw_late", OPC_LOAD, 3'b010, 1'b0, 1'b0, 0, 3);
    run_instr("sb", OPC_STORE, 3'b000, 1'b0, 1'b0, 1, 0);
    run_instr("beq_t", OPC_BRANCH, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr("bne_nt", OPC_BRANCH, 3'b001, 1'b0, 1'b1, 0, 0);
    run_instr("jalr", OPC_JALR, 3'b000, 1'b0, 1'b0, 3, 0);
    run_instr("lh", OPC_LOAD, 3'b001, 1'b0, 1'b0, 0, 0);

    // Random stream, long enough to wrap the 4-bit retire counter
    for (int n = 0; n < 30; n++) begin
      int cls = $urandom_range(0, 8);
      run_instr($sformatf("rnd%0d", n), opcs[cls], 3'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3));
    end

    // Illegal opcode: fetch, decode, then fault without retiring
    op = 7'h00; rdy = 1'b1;
    #1 chk("ill.state0", int'(o_state), ST_FETCH);
    @(posedge clk); #1;
    #1 chk("ill.state1", int'(o_state), ST_DECODE);
    chk("ill.pc_wr1", int'(o_pcw), 0);
    chk("ill.reg_wr1", int'(o_regw), 0);
    @(posedge clk); #1;
    repeat (3) begin
      #1;
      chk("ill.state", int'(o_state), ST_FAULT);
      chk("ill.fault", int'(o_fault), 1);
      chk("ill.pc_wr", int'(o_pcw), 0);
      chk("ill.reg_wr", int'(o_regw), 0);
      chk("ill.instret", int'(o_instret), retired % 16);
      @(posedge clk); #1;
    end

    // Fetch stall with timeout of 4
    do_reset();
    op = OPC_OPIMM; f3 = 3'b000; rdy = 1'b0;
    begin
      int reqc = 0;
      for (int k = 0; k < 12; k++) begin
        #1;
        if (o_state == 3'd7) break;
        reqc += int'(o_req);
        @(posedge clk); #1;
      end
      chk("tmo.req_cycles", reqc, 4);
    end
    chk("tmo.state", int'(o_state), ST_FAULT);
    chk("tmo.fault", int'(o_fault), 1);
    rdy = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("tmo.req_held", int'(o_req), 0);
      chk("tmo.state_held", int'(o_state), ST_FAULT);
    end

    // Reset in the middle of a stalled store
    do_reset();
    run_instr("pre_sw", OPC_OPIMM, 3'b000, 1'b0, 1'b0, 0, 0);
    op = OPC_STORE; f3 = 3'b010; rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    chk("rsw.state", int'(o_state), ST_MEM);
    chk("rsw.req", int'(o_req), 1);
    chk("rsw.wr", int'(o_wr), 1);
    #1 rst = 1'b1;
    #1;
    chk("rsw.req_drop", int'(o_req), 0);
    chk("rsw.wr_drop", int'(o_wr), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rsw.state_after", int'(o_state), ST_FETCH);
    chk("rsw.instret_after", int'(o_instret), 0);
    chk("rsw.fault_after", int'(o_fault), 0);
    chk("rsw.req_after", int'(o_req), 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
